// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with word-serial block refill.
// Define ICACHE_STATS_EN to add the stat_hits/stat_misses counters.
module icache_nway #(
    parameter int BLOCKSIZE = 4,
    parameter int ASSOC     = 2,
    parameter int SETS      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] address,
    output logic [31:0] data,
    output logic        hit,
    output logic        stall,
    input  logic        invalidate,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_ack
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int WORDS = 1 << (BLOCKSIZE - 2);
    localparam int NSETS = 1 << SETS;
    localparam int TW    = 32 - BLOCKSIZE - SETS;
    localparam int WW    = (BLOCKSIZE > 2) ? BLOCKSIZE - 2 : 1;
    localparam int SW    = (SETS > 0) ? SETS : 1;
    localparam int AW    = (ASSOC > 1) ? $clog2(ASSOC) : 1;

    localparam logic [WW-1:0] LAST  = WW'(WORDS - 1);
    localparam logic [31:0]   BMASK = ~((32'd1 << BLOCKSIZE) - 32'd1);

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

    state_t state;

    logic [31:0]   dmem    [NSETS][ASSOC][WORDS];
    logic [TW-1:0] tag_mem [NSETS][ASSOC];

    logic [NSETS-1:0][ASSOC-1:0] valid;
    logic [NSETS-1:0][AW-1:0]    rr;

    logic [WW-1:0] cnt;
    logic [AW-1:0] way_r;
    logic          inv_pend;

    logic [TW-1:0] a_tag;
    logic [SW-1:0] a_set;
    logic [WW-1:0] a_word;
    logic          unused;

    assign a_tag  = address[31 -: TW];
    assign a_set  = address[BLOCKSIZE +: SW];
    assign a_word = (WORDS > 1) ? address[2 +: WW] : '0;
    assign unused = ^address[1:0];

    logic          match;
    logic [AW-1:0] hit_way;
    logic [AW-1:0] victim;
    logic          all_valid;

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        match   = 1'b0;
        hit_way = '0;
        victim  = rr[a_set];
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid[a_set][w])
                victim = AW'(w);
            if (valid[a_set][w] && tag_mem[a_set][w] == a_tag) begin
                match   = 1'b1;
                hit_way = AW'(w);
            end
        end
        all_valid = &valid[a_set];
    end

    logic wr;
    logic last;

    assign wr   = (state == REFILL) && mem_req && mem_ack;
    assign last = wr && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (wr)
            dmem[a_set][way_r][cnt] <= mem_data;
        if (last)
            tag_mem[a_set][way_r] <= a_tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            way_r    <= '0;
            inv_pend <= 1'b0;
            hit      <= 1'b0;
            stall    <= 1'b0;
            data     <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            valid    <= '0;
            rr       <= '0;
`ifdef ICACHE_STATS_EN
            stat_hits   <= '0;
            stat_misses <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    hit   <= 1'b0;
                    stall <= 1'b0;
                    if (invalidate) begin
                        valid <= '0;
                    end else if (req) begin
                        if (match) begin
                            hit  <= 1'b1;
                            data <= dmem[a_set][hit_way][a_word];
`ifdef ICACHE_STATS_EN
                            stat_hits <= stat_hits + 32'd1;
`endif
                        end else begin
                            stall    <= 1'b1;
                            state    <= REFILL;
                            way_r    <= victim;
                            cnt      <= '0;
                            mem_addr <= address & BMASK;
                            if (ASSOC > 1 && all_valid)
                                rr[a_set] <= rr[a_set] + AW'(1);
`ifdef ICACHE_STATS_EN
                            stat_misses <= stat_misses + 32'd1;
`endif
                        end
                    end
                end
                REFILL: begin
                    if (invalidate)
                        inv_pend <= 1'b1;
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_addr <= mem_addr + 32'd4;
                        cnt      <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            cnt                <= '0;
                            mem_req            <= 1'b0;
                            valid[a_set][way_r] <= 1'b1;
                            stall              <= 1'b0;
                            hit                <= 1'b1;
                            state              <= RESPOND;
                            // The final beat is not in the array yet.
                            data <= (a_word == cnt) ? mem_data
                                                    : dmem[a_set][way_r][a_word];
                        end
                    end
                end
                RESPOND: begin
                    hit      <= 1'b0;
                    state    <= IDLE;
                    inv_pend <= 1'b0;
                    if (inv_pend || invalidate)
                        valid <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
